// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multiplier operand sequencer.
package mult_seq_pkg;
  localparam int BYTE_W   = 8;
  localparam int BEATS_16 = 4;
  localparam int BEATS_32 = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RESP
  } seq_state_e;
endpackage

// File: rtl/mult_byte_mux.sv
// Selects the operand byte pair presented to the multiplier on each load beat.
module mult_byte_mux
  import mult_seq_pkg::*;
(
  input  logic [31:0]       a_word,
  input  logic [31:0]       b_word,
  input  logic [3:0]        beat,
  input  logic              mode_32bit,
  input  logic              en,
  output logic [BYTE_W-1:0] data_a,
  output logic [BYTE_W-1:0] data_b
);
  logic [BYTE_W-1:0] a_bytes [4];
  logic [BYTE_W-1:0] b_bytes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign a_bytes[gi] = a_word[gi*BYTE_W +: BYTE_W];
      assign b_bytes[gi] = b_word[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // In 32x32 mode A cycles every beat while B advances once per four beats.
  always_comb begin
    data_a = '0;
    data_b = '0;
    if (en) begin
      data_a = a_bytes[beat[1:0]];
      data_b = mode_32bit ? b_bytes[beat[3:2]] : b_bytes[beat[1:0]];
    end
  end
endmodule

// File: rtl/mult_operand_sequencer.sv
// Front end for top_multiplier: accepts an operand pair, streams it bytewise,
// launches the multiply, waits for done (with timeout) and returns the result.
module mult_operand_sequencer
  import mult_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic              in_mode_32bit,
  output logic [BYTE_W-1:0] mul_data_a,
  output logic [BYTE_W-1:0] mul_data_b,
  output logic              mul_enable_2bit,
  output logic              mul_enable_4bit,
  output logic              mul_start,
  output logic              mul_mode_32bit,
  input  logic [31:0]       mul_product_1,
  input  logic [31:0]       mul_product_2,
  input  logic              mul_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_product_1,
  output logic [31:0]       out_product_2,
  output logic              out_timeout,
  output logic              busy
);
  seq_state_e state_reg, state_next;

  logic [31:0]     a_reg, b_reg;
  logic            mode_reg;
  logic [3:0]      beat_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [31:0]     prod1_reg, prod2_reg;
  logic            timeout_reg;

  logic last_beat;
  logic to_hit;
  logic in_load;

  assign in_load   = (state_reg == ST_LOAD);
  assign last_beat = mode_reg ? (beat_reg == 4'(BEATS_32 - 1))
                              : (beat_reg == 4'(BEATS_16 - 1));
  // The counter holds cycles-since-start minus one, so firing here puts
  // out_valid exactly TIMEOUT_CYCLES cycles after the start pulse.
  assign to_hit    = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (in_valid) state_next = ST_LOAD;
        ST_LOAD:  if (last_beat) state_next = ST_START;
        ST_START: state_next = ST_WAIT;
        ST_WAIT:  if (mul_done || to_hit) state_next = ST_RESP;
        ST_RESP:  if (out_ready) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      mode_reg    <= 1'b0;
      beat_reg    <= '0;
      to_cnt_reg  <= '0;
      prod1_reg   <= '0;
      prod2_reg   <= '0;
      timeout_reg <= 1'b0;
    end else if (!flush) begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            mode_reg <= in_mode_32bit;
            beat_reg <= '0;
          end
        end
        ST_LOAD:  beat_reg   <= beat_reg + 4'd1;
        ST_START: to_cnt_reg <= '0;
        ST_WAIT: begin
          to_cnt_reg <= to_cnt_reg + TO_W'(1);
          if (mul_done) begin
            prod1_reg   <= mul_product_1;
            prod2_reg   <= mul_product_2;
            timeout_reg <= 1'b0;
          end else if (to_hit) begin
            prod1_reg   <= '0;
            prod2_reg   <= '0;
            timeout_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready        = (state_reg == ST_IDLE);
    busy            = (state_reg != ST_IDLE);
    mul_enable_2bit = in_load && !mode_reg;
    mul_enable_4bit = in_load && mode_reg;
    mul_start       = (state_reg == ST_START);
    mul_mode_32bit  = mode_reg && (in_load || state_reg == ST_START || state_reg == ST_WAIT);
    out_valid       = (state_reg == ST_RESP);
    out_product_1   = prod1_reg;
    out_product_2   = prod2_reg;
    out_timeout     = timeout_reg;
  end

  mult_byte_mux u_byte_mux (
    .a_word     (a_reg),
    .b_word     (b_reg),
    .beat       (beat_reg),
    .mode_32bit (mode_reg),
    .en         (in_load),
    .data_a     (mul_data_a),
    .data_b     (mul_data_b)
  );
endmodule
